frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 216 +++++++++++++++++++++
 tb/tb_frame_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_reader
// Description : Reads one frame buffer from a 256-bit memory port and streams
//               it out as bytes, LSB first, with start-of-frame and
//               end-of-row markers. Holds at most two words in flight
//               (buffered + outstanding) so the return path never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_reader #(
  parameter int unsigned FRAME_WORDS  = 19200,
  parameter int unsigned ROW_WORDS    = 40,
  parameter logic [24:0] FRAME_STRIDE = 25'h25800
) (
  input  logic         p_clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   frame_sel,
  output logic         rd_req,
  output logic [24:0]  rd_address,
  input  logic         rd_ack,
  input  logic [255:0] rd_data,
  input  logic         rd_valid,
  output logic [7:0]   pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_sof,
  output logic         pix_eol,
  output logic         busy,
  output logic         frame_done
);

  // Counter widths: the request counter must be able to hold FRAME_WORDS
  // itself so that "all requests issued" is a plain equality.
  localparam int unsigned c_cw = $clog2(FRAME_WORDS + 1);
  localparam int unsigned c_rw = $clog2(ROW_WORDS + 1);

  localparam logic [c_cw-1:0] c_frame_words = c_cw'(FRAME_WORDS);
  localparam logic [c_cw-1:0] c_last_word   = c_cw'(FRAME_WORDS - 1);
  localparam logic [c_rw-1:0] c_last_row    = c_rw'(ROW_WORDS - 1);
  localparam logic [4:0]      c_last_byte   = 5'd31;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Request side
  logic [24:0]     rd_addr_q, rd_addr_d;
  logic [c_cw-1:0] req_cnt_q, req_cnt_d;
  logic [1:0]      out_cnt_q, out_cnt_d;

  // Two-entry word FIFO
  logic [255:0]    mem_q [2];
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;

  // Byte output side
  logic [4:0]      byte_q, byte_d;
  logic [c_cw-1:0] word_q, word_d;
  logic [c_rw-1:0] row_q, row_d;
  logic            frame_done_q, frame_done_d;

  // Combinational helpers
  logic [24:0]     w_sel_ext;
  logic [24:0]     w_base;
  logic            w_start_acc;
  logic            w_issue;
  logic            w_push;
  logic            w_pop_byte;
  logic            w_pop_word;
  logic            w_last;
  logic [2:0]      w_occupancy;
  logic [255:0]    w_head;

  // Frame buffer base address; unused selector codes fall back to buffer 0.
  always_comb begin
    w_sel_ext = {22'd0, frame_sel};
    w_base    = 25'd0;
    if (frame_sel <= 3'd5) begin
      w_base = w_sel_ext * FRAME_STRIDE;
    end
  end

  // Handshake and occupancy decode. Occupancy uses registered counts only,
  // so a pop frees its slot for a new request one cycle later.
  always_comb begin
    w_occupancy = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    w_start_acc = (state_q == S_IDLE) && start;
    rd_req      = (state_q == S_RUN) && (req_cnt_q != c_frame_words) &&
                  (w_occupancy < 3'd2);
    w_issue     = rd_req && rd_ack;
    // Returns with nothing outstanding (e.g. stale data after a reset)
    // are dropped on the floor.
    w_push      = rd_valid && (out_cnt_q != 2'd0);
    pix_valid   = (fifo_cnt_q != 2'd0);
    w_pop_byte  = pix_valid && pix_ready;
    w_pop_word  = w_pop_byte && (byte_q == c_last_byte);
    w_last      = (state_q == S_RUN) && w_pop_word && (word_q == c_last_word);
  end

  // Byte presentation straight from the FIFO head and counter registers.
  always_comb begin
    w_head     = mem_q[rd_ptr_q];
    pix_data   = 8'd0;
    pix_sof    = 1'b0;
    pix_eol    = 1'b0;
    if (pix_valid) begin
      pix_data = w_head[{byte_q, 3'b000} +: 8];
      pix_sof  = (word_q == '0) && (byte_q == 5'd0);
      pix_eol  = (byte_q == c_last_byte) && (row_q == c_last_row);
    end
    rd_address = rd_addr_q;
    busy       = (state_q == S_RUN);
    frame_done = frame_done_q;
  end

  // FSM state register.
  always_ff @(posedge p_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start opens a frame, the final accepted byte closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)  state_d = S_RUN;
      S_RUN:  if (w_last) state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // Datapath next-state for request, FIFO and byte counters.
  always_comb begin
    rd_addr_d    = rd_addr_q;
    req_cnt_d    = req_cnt_q;
    out_cnt_d    = out_cnt_q + {1'b0, w_issue} - {1'b0, w_push};
    fifo_cnt_d   = fifo_cnt_q + {1'b0, w_push} - {1'b0, w_pop_word};
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    byte_d       = byte_q;
    word_d       = word_q;
    row_d        = row_q;
    frame_done_d = w_last;

    if (w_start_acc) begin
      rd_addr_d = w_base;
      req_cnt_d = '0;
      byte_d    = 5'd0;
      word_d    = '0;
      row_d     = '0;
    end

    if (w_issue) begin
      rd_addr_d = rd_addr_q + 25'd8;
      req_cnt_d = req_cnt_q + 1'b1;
    end

    if (w_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (w_pop_byte) begin
      byte_d = byte_q + 5'd1;
    end

    if (w_pop_word) begin
      rd_ptr_d = ~rd_ptr_q;
      word_d   = word_q + 1'b1;
      row_d    = (row_q == c_last_row) ? '0 : row_q + 1'b1;
    end
  end

  // Datapath registers; reset aborts any frame in flight.
  always_ff @(posedge p_clk) begin
    if (rst) begin
      rd_addr_q    <= 25'd0;
      req_cnt_q    <= '0;
      out_cnt_q    <= 2'd0;
      fifo_cnt_q   <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      byte_q       <= 5'd0;
      word_q       <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      req_cnt_q    <= req_cnt_d;
      out_cnt_q    <= out_cnt_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      byte_q       <= byte_d;
      word_q       <= word_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are only observable through the count, so no reset.
  always_ff @(posedge p_clk) begin
    if (w_push && !rst) begin
      mem_q[wr_ptr_q] <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_reader
// Description : Directed self-checking bench for frame_reader with a
//               two-cycle-latency memory responder and a byte-stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_reader;

  localparam int FW = 120;
  localparam int RW = 40;
  localparam int FRAME_BYTES = FW * 32;

  logic         p_clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   frame_sel;
  logic         rd_req;
  logic [24:0]  rd_address;
  logic         rd_ack;
  logic [255:0] rd_data;
  logic         rd_valid;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_sof;
  logic         pix_eol;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int passed = 0;

  always #5 p_clk = ~p_clk;

  frame_reader #(
    .FRAME_WORDS (FW),
    .ROW_WORDS   (RW),
    .FRAME_STRIDE(25'h25800)
  ) dut (
    .p_clk     (p_clk),
    .rst       (rst),
    .start     (start),
    .frame_sel (frame_sel),
    .rd_req    (rd_req),
    .rd_address(rd_address),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Memory contents: byte k of the word at address a is a[10:3] + k.
  function automatic logic [7:0] pat(input logic [24:0] a, input int k);
    return a[10:3] + 8'(k);
  endfunction

  // Handshake seen by the DUT at the coming rising edge.
  logic        hs = 1'b0;
  logic [24:0] hs_addr = 25'd0;

  // Monitor state
  logic        mon_en = 1'b0;
  logic [24:0] mon_base = 25'd0;
  int          mon_n, mon_err, mon_sof, mon_eol, mon_iss, mon_addr_err;
  logic [7:0]  first_bytes [32];

  // Two-cycle latency responder.
  logic        p_v = 1'b0;
  logic [24:0] p_a = 25'd0;
  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge p_clk);
      #1;
      rd_valid = p_v;
      for (int k = 0; k < 32; k++) rd_data[k*8 +: 8] = pat(p_a, k);
      p_v = hs;
      p_a = hs_addr;
    end
  end

  // Request and byte-stream monitor, sampled on the falling edge.
  always @(negedge p_clk) begin
    hs      = rd_req && rd_ack && !rst;
    hs_addr = rd_address;
    if (mon_en) begin
      if (hs) begin
        if (rd_address !== mon_base + 25'(mon_iss * 8)) mon_addr_err++;
        mon_iss++;
      end
      if (pix_valid && pix_ready) begin
        int w, k;
        w = mon_n / 32;
        k = mon_n % 32;
        if (pix_data !== pat(mon_base + 25'(w * 8), k)) mon_err++;
        if (pix_sof !== (mon_n == 0)) mon_err++;
        if (pix_eol !== ((k == 31) && ((w + 1) % RW == 0))) mon_err++;
        if (pix_sof) mon_sof++;
        if (pix_eol) mon_eol++;
        if (mon_n < 32) first_bytes[mon_n] = pix_data;
        mon_n++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  // Called on a falling edge; returns one falling edge after the accept edge.
  task automatic do_start(input logic [2:0] sel, input logic [24:0] base);
    mon_n = 0; mon_err = 0; mon_sof = 0; mon_eol = 0;
    mon_iss = 0; mon_addr_err = 0;
    mon_base  = base;
    mon_en    = 1'b1;
    frame_sel = sel;
    start     = 1'b1;
    @(negedge p_clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(output int ok);
    ok = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge p_clk);
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_stream(input string tag, input int ok);
    checks++;
    if (ok !== 1) $display("FAIL %s_timeout: frame_done seen=%0d required 1", tag, ok);
    else passed++;
    checks++;
    if (mon_n !== FRAME_BYTES) $display("FAIL %s_bytes: got %0d required %0d", tag, mon_n, FRAME_BYTES);
    else passed++;
    checks++;
    if (mon_err !== 0 || mon_addr_err !== 0)
      $display("FAIL %s_data: byte errors %0d address errors %0d required 0", tag, mon_err, mon_addr_err);
    else passed++;
    checks++;
    if (mon_sof !== 1 || mon_eol !== FW / RW)
      $display("FAIL %s_markers: sof %0d eol %0d required 1 and %0d", tag, mon_sof, mon_eol, FW / RW);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; frame_sel = 3'd0; rd_ack = 1'b1; pix_ready = 1'b1;
    cyc(3);
    checks++;
    if ({rd_req, rd_address, pix_valid, pix_sof, pix_eol, busy, frame_done, pix_data} !== 39'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {rd_req, rd_address, pix_valid, pix_sof, pix_eol, busy, frame_done, pix_data});
    else passed++;
    rst = 1'b0;
    cyc(2);
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0)
      $display("FAIL idle_after_reset: busy %b rd_req %b required 0 0", busy, rd_req);
    else passed++;
  endtask

  task automatic test_full_frame_and_back_to_back();
    int ok, fb_err;
    do_start(3'd2, 25'h4B000);
    checks++;
    if (rd_req !== 1'b1 || rd_address !== 25'h4B000 || busy !== 1'b1)
      $display("FAIL first_req_sel2: req %b addr %h busy %b required 1 4b000 1", rd_req, rd_address, busy);
    else passed++;
    wait_done(ok);
    check_stream("sel2", ok);
    checks++;
    if (mon_iss !== FW) $display("FAIL sel2_issued: got %0d required %0d", mon_iss, FW);
    else passed++;
    fb_err = 0;
    for (int k = 0; k < 32; k++) if (first_bytes[k] !== 8'(k)) fb_err++;
    checks++;
    if (fb_err !== 0) $display("FAIL byte_order: %0d of bytes 0..31 differ from 0x00..0x1F", fb_err);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_at_done: got %b required 0", busy);
    else passed++;
    // New start in the frame_done cycle, selector 7 maps to address 0.
    do_start(3'd7, 25'd0);
    checks++;
    if (rd_req !== 1'b1 || rd_address !== 25'd0 || busy !== 1'b1)
      $display("FAIL back_to_back_sel7: req %b addr %h busy %b required 1 0 1", rd_req, rd_address, busy);
    else passed++;
    checks++;
    if (frame_done !== 1'b0) $display("FAIL done_pulse_width: got %b required 0", frame_done);
    else passed++;
    wait_done(ok);
    check_stream("sel7", ok);
  endtask

  task automatic test_backpressure();
    int ok, hold_err, seen;
    logic [7:0] d0;
    cyc(2);
    pix_ready = 1'b0;
    do_start(3'd3, 25'h70800);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (pix_valid) begin seen = 1; break; end
      @(negedge p_clk);
    end
    d0 = pix_data;
    hold_err = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge p_clk);
      if (pix_valid !== 1'b1 || pix_data !== d0 || pix_sof !== 1'b1) hold_err++;
    end
    checks++;
    if (seen !== 1 || d0 !== 8'h00)
      $display("FAIL bp_first_byte: valid seen %0d data %h required 1 00", seen, d0);
    else passed++;
    checks++;
    if (hold_err !== 0) $display("FAIL bp_hold: %0d unstable cycles required 0", hold_err);
    else passed++;
    checks++;
    if (mon_iss !== 2 || rd_req !== 1'b0)
      $display("FAIL bp_issued: reads %0d rd_req %b required 2 0", mon_iss, rd_req);
    else passed++;
    pix_ready = 1'b1;
    wait_done(ok);
    check_stream("bp", ok);
  endtask

  task automatic test_ack_stall();
    int ok, err;
    logic [24:0] a0;
    cyc(2);
    rd_ack = 1'b0;
    do_start(3'd1, 25'h25800);
    a0  = rd_address;
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (rd_req !== 1'b1 || rd_address !== a0) err++;
      @(negedge p_clk);
    end
    checks++;
    if (a0 !== 25'h25800) $display("FAIL stall_addr: got %h required 25800", a0);
    else passed++;
    checks++;
    if (err !== 0 || mon_iss !== 0)
      $display("FAIL stall_hold: %0d unstable cycles, %0d issued, required 0 0", err, mon_iss);
    else passed++;
    rd_ack = 1'b1;
    wait_done(ok);
    check_stream("stall", ok);
  endtask

  task automatic test_reset_mid();
    int ok, reached;
    cyc(2);
    do_start(3'd2, 25'h4B000);
    reached = 0;
    for (int i = 0; i < 10000; i++) begin
      if (mon_n >= 100 * 32) begin reached = 1; break; end
      @(negedge p_clk);
    end
    checks++;
    if (reached !== 1) $display("FAIL mid_reach_word100: got %0d required 1", reached);
    else passed++;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge p_clk);
    checks++;
    if ({rd_req, rd_address, pix_valid, pix_sof, pix_eol, busy, frame_done, pix_data} !== 39'd0)
      $display("FAIL mid_reset_outputs: got %h required 0",
               {rd_req, rd_address, pix_valid, pix_sof, pix_eol, busy, frame_done, pix_data});
    else passed++;
    rst = 1'b0;
    cyc(4);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stale_discard: pix_valid %b busy %b required 0 0", pix_valid, busy);
    else passed++;
    do_start(3'd0, 25'd0);
    checks++;
    if (rd_req !== 1'b1 || rd_address !== 25'd0)
      $display("FAIL restart_sel0: req %b addr %h required 1 0", rd_req, rd_address);
    else passed++;
    wait_done(ok);
    check_stream("restart", ok);
  endtask

  initial begin
    test_reset();
    test_full_frame_and_back_to_back();
    test_backpressure();
    test_ack_stall();
    test_reset_mid();
    cyc(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
